// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: registered RV32 immediate-extension stage with a two-entry
// skid buffer, flush, pass-through tag and a saturating illegal-select count.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    drop every buffered entry and any same-cycle accept
//   in_valid/in_ready        request handshake (in_ready is a flop output)
//   in_instr, in_sel, in_tag raw instruction, format select, sideband tag
//   out_valid/out_ready      result handshake
//   out_imm, out_tag, out_err extended immediate, its tag, illegal-select flag
//   err_count                saturating count of accepted in_sel=111 requests
module imm_ext_pipe #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [2:0]       in_sel,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [2:0] SEL_I     = 3'b000;
   localparam logic [2:0] SEL_S     = 3'b001;
   localparam logic [2:0] SEL_B     = 3'b010;
   localparam logic [2:0] SEL_U     = 3'b011;
   localparam logic [2:0] SEL_J     = 3'b100;
   localparam logic [2:0] SEL_SHAMT = 3'b101;
   localparam logic [2:0] SEL_ZIMM  = 3'b110;
   localparam logic [2:0] SEL_ILL   = 3'b111;

   logic [63:0]      imm64;
   logic [XLEN-1:0]  new_imm;
   logic             new_err;
   logic             accept;
   logic             drain;

   logic [XLEN-1:0]  out_imm_q,  out_imm_d;
   logic [TAG_W-1:0] out_tag_q,  out_tag_d;
   logic             out_err_q,  out_err_d;
   logic             out_vld_q,  out_vld_d;
   logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
   logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
   logic             skid_err_q, skid_err_d;
   logic             skid_vld_q, skid_vld_d;
   logic [CNT_W-1:0] err_cnt_q,  err_cnt_d;

   // Extension is built at 64 bits and truncated, so XLEN=32 needs no special
   // casing except shamt, whose field width depends on XLEN.
   always_comb begin : extend
      imm64   = '0;
      new_err = 1'b0;
      unique case (in_sel)
         SEL_I:     imm64 = {{52{in_instr[31]}}, in_instr[31:20]};
         SEL_S:     imm64 = {{52{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         SEL_B:     imm64 = {{52{in_instr[31]}}, in_instr[7], in_instr[30:25],
                             in_instr[11:8], 1'b0};
         SEL_U:     imm64 = {{32{in_instr[31]}}, in_instr[31:12], 12'b0};
         SEL_J:     imm64 = {{44{in_instr[31]}}, in_instr[19:12], in_instr[20],
                             in_instr[30:21], 1'b0};
         SEL_SHAMT: imm64 = (XLEN == 64) ? {58'b0, in_instr[25:20]}
                                         : {59'b0, in_instr[24:20]};
         SEL_ZIMM:  imm64 = {59'b0, in_instr[19:15]};
         SEL_ILL:   new_err = 1'b1;
         default:   imm64 = '0;
      endcase
   end

   assign new_imm = XLEN'(imm64);
   assign accept  = in_valid & in_ready;
   assign drain   = out_vld_q & out_ready;

   // Next state: flush beats everything; otherwise OUT refills from SKID first
   // so entries never reorder.
   always_comb begin : next_state
      out_imm_d  = out_imm_q;
      out_tag_d  = out_tag_q;
      out_err_d  = out_err_q;
      out_vld_d  = out_vld_q;
      skid_imm_d = skid_imm_q;
      skid_tag_d = skid_tag_q;
      skid_err_d = skid_err_q;
      skid_vld_d = skid_vld_q;
      err_cnt_d  = err_cnt_q;

      if (flush) begin
         out_vld_d  = 1'b0;
         skid_vld_d = 1'b0;
      end else begin
         if (accept && new_err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
         end
         if (!out_vld_q || drain) begin
            if (skid_vld_q) begin
               out_imm_d  = skid_imm_q;
               out_tag_d  = skid_tag_q;
               out_err_d  = skid_err_q;
               out_vld_d  = 1'b1;
               skid_vld_d = accept;
               if (accept) begin
                  skid_imm_d = new_imm;
                  skid_tag_d = in_tag;
                  skid_err_d = new_err;
               end
            end else begin
               out_vld_d = accept;
               if (accept) begin
                  out_imm_d = new_imm;
                  out_tag_d = in_tag;
                  out_err_d = new_err;
               end
            end
         end else if (accept) begin
            skid_imm_d = new_imm;
            skid_tag_d = in_tag;
            skid_err_d = new_err;
            skid_vld_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin : regs
      if (rst) begin
         out_imm_q  <= '0;
         out_tag_q  <= '0;
         out_err_q  <= 1'b0;
         out_vld_q  <= 1'b0;
         skid_imm_q <= '0;
         skid_tag_q <= '0;
         skid_err_q <= 1'b0;
         skid_vld_q <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         out_imm_q  <= out_imm_d;
         out_tag_q  <= out_tag_d;
         out_err_q  <= out_err_d;
         out_vld_q  <= out_vld_d;
         skid_imm_q <= skid_imm_d;
         skid_tag_q <= skid_tag_d;
         skid_err_q <= skid_err_d;
         skid_vld_q <= skid_vld_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   // in_ready comes straight from the SKID valid flop: no path from out_ready.
   assign in_ready  = ~skid_vld_q;
   assign out_valid = out_vld_q;
   assign out_imm   = out_imm_q;
   assign out_tag   = out_tag_q;
   assign out_err   = out_err_q;
   assign err_count = err_cnt_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe: XLEN=32, XLEN=64 and a CNT_W=2 instance
// share one stimulus stream.
module tb_imm_ext_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_instr;
   logic [2:0]  in_sel;
   logic [7:0]  in_tag;
   logic        out_ready;

   logic        in_ready32,  out_valid32,  out_err32;
   logic [31:0] out_imm32;
   logic [7:0]  out_tag32;
   logic [15:0] err_cnt32;

   logic        in_ready64,  out_valid64,  out_err64;
   logic [63:0] out_imm64;
   logic [7:0]  out_tag64;
   logic [15:0] err_cnt64;

   logic        in_ready_c2, out_valid_c2, out_err_c2;
   logic [31:0] out_imm_c2;
   logic [7:0]  out_tag_c2;
   logic [1:0]  err_cnt_c2;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   imm_ext_pipe #(.XLEN(32), .TAG_W(8), .CNT_W(16)) dut32 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
      .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag), .out_valid(out_valid32),
      .out_ready(out_ready), .out_imm(out_imm32), .out_tag(out_tag32),
      .out_err(out_err32), .err_count(err_cnt32));

   imm_ext_pipe #(.XLEN(64), .TAG_W(8), .CNT_W(16)) dut64 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
      .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag), .out_valid(out_valid64),
      .out_ready(out_ready), .out_imm(out_imm64), .out_tag(out_tag64),
      .out_err(out_err64), .err_count(err_cnt64));

   imm_ext_pipe #(.XLEN(32), .TAG_W(8), .CNT_W(2)) dut_c2 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_c2),
      .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag), .out_valid(out_valid_c2),
      .out_ready(out_ready), .out_imm(out_imm_c2), .out_tag(out_tag_c2),
      .out_err(out_err_c2), .err_count(err_cnt_c2));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] sel, input logic [31:0] instr, input logic [7:0] tag);
      in_valid = 1'b1;
      in_sel   = sel;
      in_instr = instr;
      in_tag   = tag;
      step();
   endtask

   // I-format word whose immediate equals the tag.
   function automatic logic [31:0] mk_i(input logic [7:0] t);
      return {4'h0, t, 20'h00013};
   endfunction

   initial begin
      int got[$];
      int nxt;
      int cyc;
      logic acc;

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
      in_sel = '0; in_tag = '0; out_ready = 1'b1;
      step(); step();
      rst = 1'b0;
      chk("rst_out_valid", 64'(out_valid32), 64'd0);
      chk("rst_out_imm",   64'(out_imm32),   64'd0);
      chk("rst_out_tag",   64'(out_tag32),   64'd0);
      chk("rst_out_err",   64'(out_err32),   64'd0);
      chk("rst_err_count", 64'(err_cnt32),   64'd0);
      chk("rst_in_ready",  64'(in_ready32),  64'd1);

      // One request per format, back to back, out_ready=1.
      send(3'b000, 32'hFFF00093, 8'h01);
      chk("i_valid", 64'(out_valid32), 64'd1);
      chk("i_imm32", 64'(out_imm32), 64'hFFFFFFFF);
      chk("i_imm64", out_imm64, 64'hFFFFFFFFFFFFFFFF);
      chk("i_tag",   64'(out_tag32), 64'h01);
      send(3'b001, 32'hFE20AE23, 8'h02);
      chk("s_imm32", 64'(out_imm32), 64'hFFFFFFFC);
      send(3'b010, 32'hFE000CE3, 8'h03);
      chk("b_imm32", 64'(out_imm32), 64'hFFFFFFF8);
      send(3'b011, 32'h123450B7, 8'h04);
      chk("u_imm32", 64'(out_imm32), 64'h12345000);
      chk("u_imm64", out_imm64, 64'h0000000012345000);
      send(3'b100, 32'hFFDFF06F, 8'h05);
      chk("j_imm32", 64'(out_imm32), 64'hFFFFFFFC);
      chk("j_imm64", out_imm64, 64'hFFFFFFFFFFFFFFFC);
      chk("j_tag",   64'(out_tag64), 64'h05);
      send(3'b101, 32'h03F0D093, 8'h06);
      chk("shamt_imm64", out_imm64, 64'h3F);
      chk("shamt_imm32", 64'(out_imm32), 64'h1F);
      send(3'b110, 32'h000FD073, 8'h07);
      chk("zimm_imm64", out_imm64, 64'h1F);
      chk("zimm_imm32", 64'(out_imm32), 64'h1F);
      chk("zimm_err",   64'(out_err32), 64'd0);
      in_valid = 1'b0;
      step();
      chk("idle_valid", 64'(out_valid32), 64'd0);

      // Backpressure: out_ready low for three edges.
      out_ready = 1'b0;
      send(3'b000, mk_i(8'd1), 8'd1);
      chk("bp_e1_tag",   64'(out_tag32), 64'd1);
      chk("bp_e1_ready", 64'(in_ready32), 64'd1);
      send(3'b000, mk_i(8'd2), 8'd2);
      chk("bp_e2_ready", 64'(in_ready32), 64'd0);
      chk("bp_e2_imm",   64'(out_imm32), 64'd1);
      send(3'b000, mk_i(8'd3), 8'd3);
      chk("bp_e3_ready", 64'(in_ready32), 64'd0);
      chk("bp_e3_imm",   64'(out_imm32), 64'd1);
      chk("bp_e3_tag",   64'(out_tag32), 64'd1);
      out_ready = 1'b1;
      got.push_back(int'(out_tag32));
      step();
      chk("bp_e4_tag",   64'(out_tag32), 64'd2);
      chk("bp_e4_ready", 64'(in_ready32), 64'd1);
      nxt = 3;
      cyc = 0;
      while ((nxt <= 6 || out_valid32) && cyc < 30) begin
         in_valid = (nxt <= 6);
         in_tag   = 8'(nxt);
         in_instr = mk_i(8'(nxt));
         if (out_valid32) got.push_back(int'(out_tag32));
         acc = in_valid && in_ready32;
         step();
         cyc++;
         if (acc) nxt++;
      end
      in_valid = 1'b0;
      chk("bp_count", 64'(got.size()), 64'd6);
      for (int i = 0; i < got.size(); i++) begin
         chk("bp_order", 64'(got[i]), 64'(i + 1));
      end

      // Flush with OUT and SKID full and in_valid high.
      out_ready = 1'b0;
      send(3'b000, mk_i(8'h10), 8'h10);
      send(3'b000, mk_i(8'h11), 8'h11);
      chk("fl1_full_ready", 64'(in_ready32), 64'd0);
      flush = 1'b1;
      send(3'b000, mk_i(8'h12), 8'h12);
      flush = 1'b0;
      in_valid = 1'b0;
      chk("fl1_valid", 64'(out_valid32), 64'd0);
      chk("fl1_ready", 64'(in_ready32), 64'd1);
      out_ready = 1'b1;
      step();
      chk("fl1_after", 64'(out_valid32), 64'd0);

      // Flush dropping a same-cycle illegal accept: no count, no output.
      out_ready = 1'b0;
      send(3'b000, mk_i(8'h13), 8'h13);
      flush = 1'b1;
      send(3'b111, 32'hFFFFFFFF, 8'h14);
      flush = 1'b0;
      in_valid = 1'b0;
      chk("fl2_valid", 64'(out_valid32), 64'd0);
      chk("fl2_ready", 64'(in_ready32), 64'd1);
      chk("fl2_errcnt", 64'(err_cnt32), 64'd0);
      out_ready = 1'b1;
      step();
      chk("fl2_after", 64'(out_valid32), 64'd0);

      // Illegal select.
      for (int k = 0; k < 3; k++) begin
         send(3'b111, 32'hFFFFFFFF, 8'(8'h21 + k));
         chk("ill_err", 64'(out_err32), 64'd1);
         chk("ill_imm", 64'(out_imm32), 64'd0);
         chk("ill_tag", 64'(out_tag32), 64'(8'h21 + k));
      end
      in_valid = 1'b0;
      step();
      chk("ill_cnt3",    64'(err_cnt32),  64'd3);
      chk("ill_cnt3_c2", 64'(err_cnt_c2), 64'd3);
      send(3'b111, 32'hFFFFFFFF, 8'h24);
      send(3'b111, 32'hFFFFFFFF, 8'h25);
      in_valid = 1'b0;
      step();
      chk("ill_cnt5",   64'(err_cnt32),  64'd5);
      chk("ill_sat_c2", 64'(err_cnt_c2), 64'd3);

      // Reset mid-stream with both entries full and in_valid high.
      out_ready = 1'b0;
      send(3'b111, 32'hFFFFFFFF, 8'h31);
      send(3'b111, 32'hFFFFFFFF, 8'h32);
      chk("mrst_pre_ready", 64'(in_ready32), 64'd0);
      rst = 1'b1;
      send(3'b000, mk_i(8'h33), 8'h33);
      rst = 1'b0;
      in_valid = 1'b0;
      chk("mrst_valid",   64'(out_valid32), 64'd0);
      chk("mrst_imm",     64'(out_imm32),   64'd0);
      chk("mrst_tag",     64'(out_tag32),   64'd0);
      chk("mrst_err",     64'(out_err32),   64'd0);
      chk("mrst_cnt",     64'(err_cnt32),   64'd0);
      chk("mrst_cnt_c2",  64'(err_cnt_c2),  64'd0);
      chk("mrst_ready",   64'(in_ready32),  64'd1);
      step();
      chk("mrst_after_valid", 64'(out_valid32), 64'd0);
      chk("mrst_after_ready", 64'(in_ready32),  64'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Parametrised, registered immediate-extension stage for the decode pipeline. It extracts and sign- or zero-extends every RV32 immediate format (I, S, B, U, J, shamt, CSR zimm) to XLEN bits. The stage has a valid/ready handshake, a two-entry skid buffer so upstream stalls never create combinational ready paths, flush support, a pass-through sideband tag, and a saturating count of illegal-format requests. It sits between instruction fetch/decode and the ID/EX register.

## Interface
Parameters:
- XLEN, 32: output width; legal values are 32 and 64.
- TAG_W, 8: width of the sideband tag carried alongside each immediate (e.g. ROB/PC index).
- CNT_W, 16: width of the illegal-selector counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  discard all buffered entries.
- in_valid  input  1  request present.
- in_ready  output  1  stage can accept a request; registered.
- in_instr  input  32  raw instruction word.
- in_sel  input  3  format select: 000 I, 001 S, 010 B, 011 U, 100 J, 101 shamt, 110 zimm, 111 illegal.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_imm  output  XLEN  extended immediate.
- out_tag  output  TAG_W  tag of the result.
- out_err  output  1  result came from in_sel=111.
- err_count  output  CNT_W  saturating count of accepted in_sel=111 requests.

## Operation
Extraction rules (i = in_instr; s = i[31] replicated to fill XLEN):
- I: {s, i[31:20]}
- S: {s, i[31:25], i[11:7]}
- B: {s, i[7], i[30:25], i[11:8], 0}
- U: {s, i[31:12], 12'b0}. For XLEN=64, bits 63:32 equal i[31].
- J: {s, i[19:12], i[20], i[30:21], 0}
- shamt: zero-extended. Uses i[24:20] when XLEN=32 and i[25:20] when XLEN=64.
- zimm: zero-extended i[19:15].
- illegal (111): the immediate is 0 and err=1.

Storage:
- One output register (OUT) and one skid register (SKID), each holding {imm, tag, err, valid}.
- Extension happens combinationally before the write, so both registers hold final values.

Accept and drain:
- accept = in_valid & in_ready.
- drain = out_valid & out_ready.
- in_ready = !SKID.valid. It is a registered signal with no combinational path from out_ready.

Next-state rules, in priority order:
- rst: OUT and SKID are cleared and err_count=0.
- flush: OUT.valid=0 and SKID.valid=0. Any request accepted in the same cycle is dropped and does not count toward err_count.
- OUT empty, or drain: OUT loads SKID if SKID is valid (the accepted request then goes to SKID), otherwise OUT loads the accepted request.
- OUT full, no drain, accept: the request goes to SKID.

Ordering and flow:
- Entries never reorder and are never duplicated or lost except on flush or rst.
- err_count increments by 1 on every non-flushed accept with in_sel=111. It saturates at 2^CNT_W−1 and does not wrap.

## Timing
- Reset values: out_valid=0, out_imm=0, out_tag=0, out_err=0, err_count=0, in_ready=1 (from the first cycle after rst deasserts).
- Latency: an accept in cycle N gives out_valid=1 with the result in cycle N+1 when OUT was empty or drained in cycle N.
- Throughput is one result per cycle while out_ready=1.
- Stall:
  - If out_ready=0 while OUT is full, one further accept fills SKID.
  - in_ready then falls in the next cycle.
  - In that falling cycle in_valid may be high but is not accepted.
- Recovery: the first drain with SKID full moves SKID into OUT, and in_ready returns to 1 in the following cycle.
- Output stability: out_imm, out_tag and out_err are held stable while out_valid=1 and out_ready=0.
- Flush timing: a flush in cycle N gives out_valid=0 and in_ready=1 in cycle N+1.
- Reset mid-stream has the same effect as flush and also clears err_count.

## Test plan
- XLEN=32, one request per format with out_ready=1. Each must appear in the next cycle:
  - I, 0xFFF00093 → 0xFFFFFFFF
  - S, 0xFE20AE23 → 0xFFFFFFFC
  - B, 0xFE000CE3 → 0xFFFFFFF8
  - U, 0x123450B7 → 0x12345000
  - J, 0xFFDFF06F → 0xFFFFFFFC
- XLEN=64:
  - J, 0xFFDFF06F → 0xFFFFFFFFFFFFFFFC
  - shamt, 0x03F0D093 → 0x3F
  - zimm, 0x000FD073 → 0x1F
- Backpressure: stream tags 1..6 with out_ready held 0 for 3 cycles.
  - in_ready must fall after 2 accepts.
  - Outputs must then emerge as tags 1..6 in order, with none lost or duplicated.
  - out_imm must stay stable while stalled.
- Flush with OUT and SKID full and in_valid=1 in the same cycle:
  - Next cycle out_valid=0 and in_ready=1.
  - The flushed requests never appear at the output.
- Illegal select: send 3 requests with in_sel=111 and out_imm=0. Expect out_err=1 on each and err_count=3.
  - With CNT_W=2, send 5 requests; err_count must saturate at 3.
- Assert rst for 1 cycle mid-stream:
  - All outputs must return to their reset values.
  - in_ready must be 1 in the next cycle.
